// File: rtl/rbus_multi_cfg.sv
// rtl/rbus_multi_cfg.sv - reconfigurable control bus routing NUM_CH channels onto LENGTHBUS lanes
//
// Ports:
//   RBUSP_Clk, RBUSP_Reset            clock, asynchronous active-high reset
//   RBUSP_Set_Conf                    start/restart table configuration (level)
//   RBUSP_Set_Conf_Ack                acknowledge a finished configuration, enables the bus
//   RBUSP_Mode                        0 = sparse (last lane of each column group), 1 = dense
//   RBUSP_W_Colums                    lanes per channel group
//   RBUSP_Lanes_Used                  number of lanes mapped, starting at lane 0
//   RBUSP_Ch_Offset                   first channel index used
//   RBUSP_In_{SetEn,OEn,Wptclr,Rptclr}  per-channel controls, bit k = channel k
//   RBUSP_Om_{SetEn,OEn,Wptclr,Rptclr}  per-lane controls
//   RBUSP_Conf_Done, RBUSP_Busy, RBUSP_Conf_Err  configuration status
module rbus_multi_cfg #(
    parameter int LENGTHBUS         = 169,
    parameter int NUM_CH            = 13,
    parameter int BITWIDTH_W_COLUMS = 4,
    parameter int BITWIDTH_LANE     = 8,
    parameter int SEL_W             = 4,
    parameter int OUT_REG           = 0
) (
    input  logic                         RBUSP_Clk,
    input  logic                         RBUSP_Reset,
    input  logic                         RBUSP_Set_Conf,
    input  logic                         RBUSP_Set_Conf_Ack,
    input  logic                         RBUSP_Mode,
    input  logic [BITWIDTH_W_COLUMS-1:0] RBUSP_W_Colums,
    input  logic [BITWIDTH_LANE-1:0]     RBUSP_Lanes_Used,
    input  logic [SEL_W-1:0]             RBUSP_Ch_Offset,
    input  logic [NUM_CH-1:0]            RBUSP_In_SetEn,
    input  logic [NUM_CH-1:0]            RBUSP_In_OEn,
    input  logic [NUM_CH-1:0]            RBUSP_In_Wptclr,
    input  logic [NUM_CH-1:0]            RBUSP_In_Rptclr,
    output logic [LENGTHBUS-1:0]         RBUSP_Om_SetEn,
    output logic [LENGTHBUS-1:0]         RBUSP_Om_OEn,
    output logic [LENGTHBUS-1:0]         RBUSP_Om_Wptclr,
    output logic [LENGTHBUS-1:0]         RBUSP_Om_Rptclr,
    output logic                         RBUSP_Conf_Done,
    output logic                         RBUSP_Busy,
    output logic                         RBUSP_Conf_Err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONF   = 2'd1,
        ST_DONE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // configuration snapshot taken when CONF is entered
    logic                         cfg_mode;
    logic [BITWIDTH_W_COLUMS-1:0] cfg_cols;
    logic [BITWIDTH_LANE-1:0]     cfg_lanes;

    logic [BITWIDTH_LANE-1:0]     lane_cnt;
    logic [BITWIDTH_W_COLUMS-1:0] col_cnt;
    logic [SEL_W-1:0]             ch_cnt;
    logic                         conf_err;

    // entry 0 = lane idle, entry s = lane follows channel s-1
    logic [SEL_W-1:0]             sel_tab [LENGTHBUS];

    logic                         conf_start;
    logic                         last_lane;
    logic                         col_wrap;
    logic                         cols_zero;
    logic                         need_ch;
    logic                         ch_avail;
    logic                         ch_step;
    logic                         entry_err;
    logic [SEL_W-1:0]             entry;

    always_ff @(posedge RBUSP_Clk or posedge RBUSP_Reset) begin
        if (RBUSP_Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A restart request in DONE wins over a simultaneous acknowledge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (RBUSP_Set_Conf) state_nxt = ST_CONF;
            ST_CONF:   if (last_lane) state_nxt = ST_DONE;
            ST_DONE: begin
                if (RBUSP_Set_Conf)          state_nxt = ST_CONF;
                else if (RBUSP_Set_Conf_Ack) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: if (RBUSP_Set_Conf) state_nxt = ST_CONF;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign conf_start = (state != ST_CONF) && (state_nxt == ST_CONF);

    // Entry generation for the lane currently addressed by lane_cnt.
    // In sparse mode only the last lane of each column group takes a channel;
    // in dense mode every eligible lane does and the channel advances at group end.
    always_comb begin
        last_lane = (lane_cnt == BITWIDTH_LANE'(LENGTHBUS - 1));
        col_wrap  = (col_cnt == cfg_cols);
        cols_zero = (cfg_cols == '0);
        need_ch   = !cols_zero && (lane_cnt < cfg_lanes) && (cfg_mode || col_wrap);
        ch_avail  = (ch_cnt < SEL_W'(NUM_CH));
        ch_step   = need_ch && ch_avail && col_wrap;
        entry_err = cols_zero || (need_ch && !ch_avail);
        entry     = (need_ch && ch_avail) ? ch_cnt + SEL_W'(1) : '0;
    end

    always_ff @(posedge RBUSP_Clk or posedge RBUSP_Reset) begin
        if (RBUSP_Reset) begin
            cfg_mode  <= 1'b0;
            cfg_cols  <= '0;
            cfg_lanes <= '0;
            lane_cnt  <= '0;
            col_cnt   <= '0;
            ch_cnt    <= '0;
            conf_err  <= 1'b0;
        end else if (conf_start) begin
            cfg_mode  <= RBUSP_Mode;
            cfg_cols  <= RBUSP_W_Colums;
            cfg_lanes <= RBUSP_Lanes_Used;
            lane_cnt  <= '0;
            col_cnt   <= BITWIDTH_W_COLUMS'(1);
            ch_cnt    <= RBUSP_Ch_Offset;
            conf_err  <= 1'b0;
        end else if (state == ST_CONF) begin
            lane_cnt <= lane_cnt + BITWIDTH_LANE'(1);
            col_cnt  <= col_wrap ? BITWIDTH_W_COLUMS'(1) : col_cnt + BITWIDTH_W_COLUMS'(1);
            // channel counter saturates at NUM_CH, it never wraps
            if (ch_step) begin
                ch_cnt <= ch_cnt + SEL_W'(1);
            end
            if (entry_err) begin
                conf_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge RBUSP_Clk or posedge RBUSP_Reset) begin
        if (RBUSP_Reset) begin
            for (int i = 0; i < LENGTHBUS; i++) begin
                sel_tab[i] <= '0;
            end
        end else if (state == ST_CONF) begin
            for (int i = 0; i < LENGTHBUS; i++) begin
                if (lane_cnt == BITWIDTH_LANE'(i)) begin
                    sel_tab[i] <= entry;
                end
            end
        end
    end

    // Lane mux; the table is only read in ACTIVE so it is never read while written.
    logic [LENGTHBUS-1:0] om_set_c, om_oen_c, om_wpt_c, om_rpt_c;

    always_comb begin
        om_set_c = '0;
        om_oen_c = '0;
        om_wpt_c = '0;
        om_rpt_c = '0;
        if (state == ST_ACTIVE) begin
            for (int i = 0; i < LENGTHBUS; i++) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (sel_tab[i] == SEL_W'(k + 1)) begin
                        om_set_c[i] = RBUSP_In_SetEn[k];
                        om_oen_c[i] = RBUSP_In_OEn[k];
                        om_wpt_c[i] = RBUSP_In_Wptclr[k];
                        om_rpt_c[i] = RBUSP_In_Rptclr[k];
                    end
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [LENGTHBUS-1:0] om_set_q, om_oen_q, om_wpt_q, om_rpt_q;

            always_ff @(posedge RBUSP_Clk or posedge RBUSP_Reset) begin
                if (RBUSP_Reset) begin
                    om_set_q <= '0;
                    om_oen_q <= '0;
                    om_wpt_q <= '0;
                    om_rpt_q <= '0;
                end else begin
                    om_set_q <= om_set_c;
                    om_oen_q <= om_oen_c;
                    om_wpt_q <= om_wpt_c;
                    om_rpt_q <= om_rpt_c;
                end
            end

            assign RBUSP_Om_SetEn  = om_set_q;
            assign RBUSP_Om_OEn    = om_oen_q;
            assign RBUSP_Om_Wptclr = om_wpt_q;
            assign RBUSP_Om_Rptclr = om_rpt_q;
        end else begin : g_out_comb
            assign RBUSP_Om_SetEn  = om_set_c;
            assign RBUSP_Om_OEn    = om_oen_c;
            assign RBUSP_Om_Wptclr = om_wpt_c;
            assign RBUSP_Om_Rptclr = om_rpt_c;
        end
    endgenerate

    assign RBUSP_Conf_Done = (state == ST_DONE);
    assign RBUSP_Busy      = (state == ST_CONF);
    assign RBUSP_Conf_Err  = conf_err;

endmodule
